bram_sweep: RTL
===============

# bram_sweep

Parametrised simple-dual-port block RAM with per-lane write enables, a read-valid handshake, and a multi-cycle hardware clear sequencer. The clear sequencer replaces single-cycle whole-array clearing with a one-address-per-cycle sweep, so the array maps onto real BRAM primitives. It serves as the storage element behind command/coordinate buffers in the plotter datapath.

## Interface
- ADDR_BITS, 8, address width; depth = 2**ADDR_BITS words
- DATA_BITS, 64, word width
- LANE_BITS, 8, write-lane width; DATA_BITS must be a multiple of LANE_BITS; LANES = DATA_BITS/LANE_BITS
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  request a clear sweep; sampled per cycle
- rd_en  in  1  read request
- rd_addr  in  ADDR_BITS  read address
- wr_en  in  1  write request
- wr_addr  in  ADDR_BITS  write address
- wr_be  in  LANES  per-lane write enable; bit i covers wr_data[i*LANE_BITS +: LANE_BITS]
- wr_data  in  DATA_BITS  write data
- rd_data  out  DATA_BITS  read data; holds last value when no read completes
- rd_valid  out  1  one-cycle pulse: rd_data updated this cycle
- busy  out  1  clear sweep in progress; reads and writes not accepted

## Operation
- FSM states: SWEEP, IDLE.
- Reset: async. Enters SWEEP with sweep pointer 0; rd_data=0, rd_valid=0, busy=1. Array contents are not reset directly; the sweep zeroes them.
- SWEEP:
  - Each cycle writes 0 to mem[ptr], then ptr increments.
  - When ptr = 2**ADDR_BITS-1 is written, go to IDLE.
  - rd_en and wr_en are ignored: no array write, rd_valid=0.
- IDLE:
  - clear=1 enters SWEEP with ptr=0 and ignores any same-cycle rd_en/wr_en.
  - Otherwise the read and write are independent.
  - Write: lanes with wr_be[i]=1 are updated; other lanes are kept. wr_be=0 with wr_en=1 is a no-op.
  - Read: rd_en=1 loads rd_data with mem[rd_addr] and pulses rd_valid.
- clear while in SWEEP restarts ptr at 0.
- Precedence: reset > clear/sweep > user read/write.
- Same-address read and write in the same cycle: see Configuration.
- Pointer is ADDR_BITS+0 wide with a separate last-address compare; no wrap into a second pass.

## Timing
- Read latency 1: rd_en sampled at edge k → rd_data/rd_valid valid after edge k, for one cycle only.
- Write visible to a read sampled at the edge after the write edge.
- Sweep length: exactly 2**ADDR_BITS cycles.
  - From reset deassertion: busy=1 for 2**ADDR_BITS rising edges, then 0.
  - From clear sampled at edge k: busy rises after edge k and falls after edge k+2**ADDR_BITS.
- busy is registered, never combinational from clear.
- Back-to-back reads every cycle are supported, giving a continuous rd_valid.
- Reset asserted mid-sweep or mid-read: outputs go to reset values immediately and the sweep restarts from 0.

## Configuration
- BRAM_SWEEP_FWD_EN:
  - Defined: same-cycle rd_en and wr_en to the same address return write-first data, i.e. old word with wr_be lanes replaced by wr_data.
  - Undefined: read-first, returning the pre-write word.
  - Either way the array holds the merged word afterwards.

## Structure
- bram_pkg holds:
  - the state enum (SWEEP, IDLE) type bram_state_t
  - the lane-merge function merge_lanes(old, new, be)
- Sub-module bram_clear_seq implements the FSM, pointer, last-address detect and busy. The top level holds the array, the write muxing and the read register.

## Test plan
Parameters: ADDR_BITS=4, DATA_BITS=16, LANE_BITS=8.
- Reset release → busy=1 for exactly 16 cycles. Then reading addresses 0..15 back-to-back gives rd_valid on 16 consecutive cycles, all rd_data=16'h0000.
- Write addr 3 = 16'hA5C3 with wr_be=2'b11, then write addr 3 = 16'h1200 with wr_be=2'b10; read 3 → rd_data=16'h12C3, rd_valid one cycle after rd_en.
- Addr 5 holds 16'h1111. Same-cycle write addr 5 = 16'h2222 (be=11) and read addr 5 → 16'h2222 with BRAM_SWEEP_FWD_EN, 16'h1111 without. A following read gives 16'h2222 in both builds.
- Fill all addresses with 16'hFFFF, pulse clear, and issue wr_en to addr 0 during the sweep. busy=1 for 16 cycles, rd_valid stays 0 throughout, and all reads afterwards are 16'h0000.
- Pulse clear, then pulse clear again after 7 cycles → busy stays high for 16 more cycles (23 total).
- Assert reset mid-sweep at ptr=9 with rd_valid pending → rd_data=0 and rd_valid=0 immediately. After release, busy=1 for exactly 16 cycles.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared types and helpers for the bram_sweep block RAM.
// Holds the clear-sequencer state type and the lane-merge helper.
package bram_pkg;

   typedef enum logic [0:0] {
      SWEEP = 1'b0,
      IDLE  = 1'b1
   } bram_state_t;

   localparam int MAX_DATA_BITS = 512;

   // Replace the lanes of old_word selected by be with the matching lanes of new_word.
   function automatic logic [MAX_DATA_BITS-1:0] merge_lanes(
      input logic [MAX_DATA_BITS-1:0] old_word,
      input logic [MAX_DATA_BITS-1:0] new_word,
      input logic [MAX_DATA_BITS-1:0] be,
      input int                       lane_bits
   );
      logic [MAX_DATA_BITS-1:0] res;
      int lane;
      int cnt;
      res  = old_word;
      lane = 0;
      cnt  = 0;
      for (int i = 0; i < MAX_DATA_BITS; i++) begin
         if (be[lane]) begin
            res[i] = new_word[i];
         end else begin
            res[i] = old_word[i];
         end
         cnt = cnt + 1;
         if (cnt == lane_bits) begin
            cnt  = 0;
            lane = lane + 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bram_sweep_if.sv
// Request/response bundle of the bram_sweep block RAM.
interface bram_sweep_if #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 64,
   parameter int LANE_BITS = 8
);
   localparam int LANES = DATA_BITS / LANE_BITS;

   logic                 clear;
   logic                 rd_en;
   logic [ADDR_BITS-1:0] rd_addr;
   logic                 wr_en;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [LANES-1:0]     wr_be;
   logic [DATA_BITS-1:0] wr_data;
   logic [DATA_BITS-1:0] rd_data;
   logic                 rd_valid;
   logic                 busy;

   modport master (
      output clear, rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data,
      input  rd_data, rd_valid, busy
   );

   modport slave (
      input  clear, rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data,
      output rd_data, rd_valid, busy
   );
endinterface

// File: rtl/bram_clear_seq.sv
// Clear sequencer: walks the sweep pointer over every address once,
// then parks in IDLE until the next clear request or reset.
module bram_clear_seq
   import bram_pkg::*;
#(
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   output logic                 busy,
   output logic [ADDR_BITS-1:0] ptr
);
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

   bram_state_t          state_r;
   bram_state_t          state_nx_s;
   logic [ADDR_BITS-1:0] ptr_r;
   logic [ADDR_BITS-1:0] ptr_nx_s;

   // State and pointer registers; reset starts a fresh sweep.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= SWEEP;
         ptr_r   <= '0;
      end else begin
         state_r <= state_nx_s;
         ptr_r   <= ptr_nx_s;
      end
   end

   // Next-state logic; a clear in either state restarts from address 0.
   always_comb begin
      state_nx_s = state_r;
      ptr_nx_s   = ptr_r;
      case (state_r)
         SWEEP: begin
            if (clear) begin
               ptr_nx_s = '0;
            end else if (ptr_r == LAST_ADDR) begin
               state_nx_s = IDLE;
               ptr_nx_s   = '0;
            end else begin
               ptr_nx_s = ptr_r + ADDR_BITS'(1);
            end
         end
         IDLE: begin
            if (clear) begin
               state_nx_s = SWEEP;
               ptr_nx_s   = '0;
            end else begin
               ptr_nx_s = ptr_r;
            end
         end
         default: begin
            state_nx_s = SWEEP;
            ptr_nx_s   = '0;
         end
      endcase
   end

   assign busy = (state_r == SWEEP);
   assign ptr  = ptr_r;

endmodule

// File: rtl/bram_sweep.sv
// Simple-dual-port block RAM with lane write enables and a sweeping clear.
// Define BRAM_SWEEP_FWD_EN for write-first same-address reads (default read-first).
module bram_sweep
   import bram_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 64,
   parameter int LANE_BITS = 8
) (
   input logic         clk,
   input logic         reset,
   bram_sweep_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam int LANES = DATA_BITS / LANE_BITS;

   logic [DATA_BITS-1:0] mem_r [DEPTH];
   logic [DATA_BITS-1:0] rd_data_r;
   logic                 rd_valid_r;
   logic [DATA_BITS-1:0] rd_word_s;
   logic                 busy_s;
   logic [ADDR_BITS-1:0] ptr_s;
   logic                 user_ok_s;

   bram_clear_seq #(
      .ADDR_BITS(ADDR_BITS)
   ) u_clear_seq (
      .clk  (clk),
      .reset(reset),
      .clear(bus.clear),
      .busy (busy_s),
      .ptr  (ptr_s)
   );

   // User traffic is dropped while sweeping and on the cycle a clear is taken.
   assign user_ok_s = !busy_s && !bus.clear;

   // Array write port: sweep zeroing has priority over lane-masked user writes.
   always_ff @(posedge clk) begin
      if (busy_s) begin
         mem_r[ptr_s] <= '0;
      end else if (user_ok_s && bus.wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.wr_be[i]) begin
               mem_r[bus.wr_addr][i*LANE_BITS +: LANE_BITS] <= bus.wr_data[i*LANE_BITS +: LANE_BITS];
            end
         end
      end
   end

   // Word presented to the read register, with optional write-first bypass.
   always_comb begin
      rd_word_s = mem_r[bus.rd_addr];
`ifdef BRAM_SWEEP_FWD_EN
      if (bus.wr_en && (bus.wr_addr == bus.rd_addr)) begin
         rd_word_s = DATA_BITS'(merge_lanes(MAX_DATA_BITS'(mem_r[bus.rd_addr]),
                                            MAX_DATA_BITS'(bus.wr_data),
                                            MAX_DATA_BITS'(bus.wr_be),
                                            LANE_BITS));
      end else begin
         rd_word_s = mem_r[bus.rd_addr];
      end
`else
      rd_word_s = mem_r[bus.rd_addr];
`endif
   end

   // Read register; rd_data holds its value when no read completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_r  <= '0;
         rd_valid_r <= 1'b0;
      end else if (user_ok_s && bus.rd_en) begin
         rd_data_r  <= rd_word_s;
         rd_valid_r <= 1'b1;
      end else begin
         rd_valid_r <= 1'b0;
      end
   end

   assign bus.rd_data  = rd_data_r;
   assign bus.rd_valid = rd_valid_r;
   assign bus.busy     = busy_s;

endmodule
